// File: rtl/alu_pkg.sv
// Shared width, opcode encodings and the full-adder helper for the 4-bit toy-processor ALU.
package alu_pkg;

   localparam int ALU_W = 4;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_INC = 3'b110;
   localparam logic [2:0] OP_DEC = 3'b111;

   // One full-adder stage: returns {carry_out, sum_bit}.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
      return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
   endfunction

endpackage

// File: rtl/alu_ripple_adder4.sv
// 4-bit ripple-carry adder built from a chain of full-adder stages.
module alu_ripple_adder4
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] x,
   input  logic [ALU_W-1:0] y,
   input  logic             cin,
   output logic [ALU_W-1:0] s,
   output logic             cout
);

   logic [ALU_W:0] carry_s;

   assign carry_s[0] = cin;

   for (genvar i = 0; i < ALU_W; i++) begin : g_fa
      assign {carry_s[i+1], s[i]} = full_add(x[i], y[i], carry_s[i]);
   end

   assign cout = carry_s[ALU_W];

endmodule

// File: rtl/alu_lab_instructions.sv
// 4-bit ALU execute unit: logic ops for M=0, shared-adder arithmetic for M=1, outputs registered.
module alu_lab_instructions
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [ALU_W-1:0] A,
   input  logic [ALU_W-1:0] B,
   input  logic             M,
   input  logic             S1,
   input  logic             S0,
   output logic             c_out,
   output logic [ALU_W-1:0] SUM
);

   logic [2:0]       op_s;
   logic [ALU_W-1:0] add_y_s;
   logic             add_cin_s;
   logic [ALU_W-1:0] add_sum_s;
   logic             add_cout_s;
   logic [ALU_W-1:0] logic_res_s;
   logic [ALU_W-1:0] result_s;
   logic             carry_s;
   logic [ALU_W-1:0] sum_r;
   logic             c_out_r;

   assign op_s = {M, S1, S0};

   // Operand-Y and carry-in selection; SUB is A + ~B + 1, DEC is A + 1111.
   always_comb begin
      add_y_s   = {ALU_W{1'b0}};
      add_cin_s = 1'b0;
      case (op_s)
         OP_ADD: begin
            add_y_s   = B;
            add_cin_s = 1'b0;
         end
         OP_SUB: begin
            add_y_s   = ~B;
            add_cin_s = 1'b1;
         end
         OP_INC: begin
            add_y_s   = {ALU_W{1'b0}};
            add_cin_s = 1'b1;
         end
         OP_DEC: begin
            add_y_s   = {ALU_W{1'b1}};
            add_cin_s = 1'b0;
         end
         default: begin
            add_y_s   = {ALU_W{1'b0}};
            add_cin_s = 1'b0;
         end
      endcase
   end

   alu_ripple_adder4 u_adder (
      .x    (A),
      .y    (add_y_s),
      .cin  (add_cin_s),
      .s    (add_sum_s),
      .cout (add_cout_s)
   );

   // Logic unit, selected by the low two opcode bits.
   always_comb begin
      logic_res_s = {ALU_W{1'b0}};
      case (op_s[1:0])
         2'b00:   logic_res_s = A & B;
         2'b01:   logic_res_s = A | B;
         2'b10:   logic_res_s = A ^ B;
         2'b11:   logic_res_s = ~A;
         default: logic_res_s = {ALU_W{1'b0}};
      endcase
   end

   // Result mux: the carry flag is forced low for logic operations.
   always_comb begin
      result_s = {ALU_W{1'b0}};
      carry_s  = 1'b0;
      if (op_s[2]) begin
         result_s = add_sum_s;
         carry_s  = add_cout_s;
      end else begin
         result_s = logic_res_s;
         carry_s  = 1'b0;
      end
   end

   // Output registers; reset discards the operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_r   <= {ALU_W{1'b0}};
         c_out_r <= 1'b0;
      end else begin
         sum_r   <= result_s;
         c_out_r <= carry_s;
      end
   end

   assign SUM   = sum_r;
   assign c_out = c_out_r;

endmodule

// File: tb/tb_alu_lab_instructions.sv
// Table-driven and randomized self-checking bench for alu_lab_instructions.
module tb_alu_lab_instructions;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] A;
   logic [3:0] B;
   logic       M;
   logic       S1;
   logic       S0;
   logic       c_out;
   logic [3:0] SUM;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      name;
      logic       rst;
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic [3:0] exp_sum;
      logic       exp_c;
   } vec_t;

   vec_t vecs[$];

   alu_lab_instructions dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .M     (M),
      .S1    (S1),
      .S0    (S0),
      .c_out (c_out),
      .SUM   (SUM)
   );

   always #5 clk = ~clk;

   // Reference model from the operation table, using plain integer arithmetic.
   function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      int ia;
      int ib;
      ia = int'(a);
      ib = int'(b);
      case (op)
         3'd0: return {1'b0, a & b};
         3'd1: return {1'b0, a | b};
         3'd2: return {1'b0, a ^ b};
         3'd3: return {1'b0, ~a};
         3'd4: return 5'((ia + ib));
         3'd5: return {(ia >= ib) ? 1'b1 : 1'b0, 4'((ia - ib + 16) % 16)};
         3'd6: return 5'((ia + 1));
         3'd7: return {(ia != 0) ? 1'b1 : 1'b0, 4'((ia + 15) % 16)};
         default: return 5'd0;
      endcase
   endfunction

   task automatic add_vec(input string name, input logic r, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input logic [3:0] es, input logic ec);
      vec_t v;
      v.name = name; v.rst = r; v.a = a; v.b = b; v.op = op; v.exp_sum = es; v.exp_c = ec;
      vecs.push_back(v);
   endtask

   // Drive one operation, clock it in, then compare just after the edge.
   task automatic step(input string name, input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [3:0] es, input logic ec);
      rst = r; A = a; B = b; {M, S1, S0} = op;
      @(posedge clk);
      #1;
      checks++;
      if (SUM !== es || c_out !== ec) begin
         failures++;
         $display("FAIL %s: got SUM=%b c_out=%b, expected SUM=%b c_out=%b", name, SUM, c_out, es, ec);
      end
   endtask

   initial begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic [2:0] rop;
      logic       rr;
      logic [4:0] exp;

      rst = 1'b1; A = 4'd0; B = 4'd0; {M, S1, S0} = 3'b000;

      add_vec("reset0",   1'b1, 4'b1010, 4'b0101, 3'b100, 4'b0000, 1'b0);
      add_vec("reset1",   1'b1, 4'b1010, 4'b0101, 3'b100, 4'b0000, 1'b0);
      add_vec("release",  1'b0, 4'b1010, 4'b0101, 3'b100, 4'b1111, 1'b0);
      add_vec("sw_and",   1'b0, 4'b1010, 4'b0101, 3'b000, 4'b0000, 1'b0);
      add_vec("sw_or",    1'b0, 4'b1010, 4'b0101, 3'b001, 4'b1111, 1'b0);
      add_vec("sw_xor",   1'b0, 4'b1010, 4'b0101, 3'b010, 4'b1111, 1'b0);
      add_vec("sw_not",   1'b0, 4'b1010, 4'b0101, 3'b011, 4'b0101, 1'b0);
      add_vec("sw_add",   1'b0, 4'b1010, 4'b0101, 3'b100, 4'b1111, 1'b0);
      add_vec("sw_sub",   1'b0, 4'b1010, 4'b0101, 3'b101, 4'b0101, 1'b1);
      add_vec("sw_inc",   1'b0, 4'b1010, 4'b0101, 3'b110, 4'b1011, 1'b0);
      add_vec("sw_dec",   1'b0, 4'b1010, 4'b0101, 3'b111, 4'b1001, 1'b1);
      add_vec("add_wrap", 1'b0, 4'b1111, 4'b0001, 3'b100, 4'b0000, 1'b1);
      add_vec("inc_wrap", 1'b0, 4'b1111, 4'b0110, 3'b110, 4'b0000, 1'b1);
      add_vec("dec_zero", 1'b0, 4'b0000, 4'b0110, 3'b111, 4'b1111, 1'b0);
      add_vec("sub_brw",  1'b0, 4'b0011, 4'b0101, 3'b101, 4'b1110, 1'b0);
      add_vec("sub_eq",   1'b0, 4'b0101, 4'b0101, 3'b101, 4'b0000, 1'b1);
      add_vec("ms_and",   1'b0, 4'b1010, 4'b0101, 3'b000, 4'b0000, 1'b0);
      add_vec("ms_rst",   1'b1, 4'b1010, 4'b0101, 3'b001, 4'b0000, 1'b0);
      add_vec("ms_xor",   1'b0, 4'b1010, 4'b0101, 3'b010, 4'b1111, 1'b0);
      add_vec("ms_not",   1'b0, 4'b1010, 4'b0101, 3'b011, 4'b0101, 1'b0);
      add_vec("ms_add",   1'b0, 4'b1010, 4'b0101, 3'b100, 4'b1111, 1'b0);

      @(negedge clk);
      foreach (vecs[i])
         step(vecs[i].name, vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].op,
              vecs[i].exp_sum, vecs[i].exp_c);

      // Back-to-back random operations with occasional reset pulses.
      for (int n = 0; n < 400; n++) begin
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         rop = 3'($urandom_range(0, 7));
         rr  = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
         exp = rr ? 5'd0 : model(ra, rb, rop);
         step("random", rr, ra, rb, rop, exp[3:0], exp[4]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
